ram_test_cmd_decoder: RTL
=========================

// Module: ram_test_cmd_decoder
// PURPOSE
// - Byte-stream command decoder for the block-RAM test harness. Consumes received bytes, assembles address/data,
//   drives data-register byte strobes and the RAM port, and returns reply bytes on a valid/ready TX channel.
// - Sits directly upstream of the 16-bit byte-loadable data register: it generates that register's low/high
//   write strobes and byte-replicated input word, and consumes the register's output for RAM writes.
// PARAMETERS
// - ADDR_W  10  RAM address width (1..16); upper bits of the received 16-bit address are discarded
// PORTS
// - clk_i         in   1       single clock, all logic on rising edge
// - rst_ni        in   1       synchronous reset, active low
// - rx_data_i     in   8       received byte
// - rx_valid_i    in   1       one-cycle strobe, rx_data_i valid; no backpressure
// - reg_wdata_o   out  16      {byte,byte} to data register input; byte = current payload byte
// - reg_wr_lo_o   out  1       data register low-byte load strobe
// - reg_wr_hi_o   out  1       data register high-byte load strobe
// - reg_q_i       in   16      data register output (value written to RAM)
// - ram_addr_o    out  ADDR_W  RAM address
// - ram_we_o      out  1       RAM write enable, one cycle, data = reg_q_i
// - ram_rdata_i   in   16      RAM read data, valid 1 cycle after address presented
// - tx_data_o     out  8       reply byte
// - tx_valid_o    out  1       reply byte valid; held with tx_data_o stable until tx_ready_i
// - tx_ready_i    in   1       downstream accepts byte when tx_valid_o & tx_ready_i
// - busy_o        out  1       high in any state other than IDLE
// - err_o         out  1       one-cycle pulse: bad opcode or byte dropped
// BEHAVIOUR
// - Reset (rst_ni=0 at edge): state IDLE; all outputs 0; ram_addr_o=0; address/read latches 0. Reset mid-frame
//   abandons the frame and any pending TX byte; no RAM write issued.
// - Frames: 'W' 0x57, AH, AL, DH, DL -> write; 'R' 0x52, AH, AL -> read. Bytes consumed only when rx_valid_i=1.
// - States: IDLE -> (opcode) ADDR_H -> ADDR_L -> [W] DATA_H -> DATA_L -> COMMIT -> TX_ACK -> IDLE
//                                                [R] RD_WAIT -> RD_CAP -> TX_H -> TX_L -> IDLE; bad opcode -> TX_ERR -> IDLE.
// - ADDR_L: on byte, ram_addr_o <= {AH,AL}[ADDR_W-1:0] registered, visible next cycle.
// - DATA_H byte: same cycle reg_wr_hi_o=1, reg_wdata_o={DH,DH} (combinational from rx_data_i); DATA_L likewise lo.
// - COMMIT: one cycle after DL strobe; ram_we_o=1 for exactly 1 cycle with reg_q_i already updated.
// - TX_ACK: tx_data_o=0x4B ('K'). TX_ERR: tx_data_o=0x3F ('?'), err_o pulses on the opcode-reject cycle.
// - Read: RD_WAIT 1 cycle (RAM latency), RD_CAP latches ram_rdata_i; TX_H sends hi byte, TX_L lo byte.
// - TX states: tx_valid_o=1; advance only on tx_valid_o & tx_ready_i; byte never changes while unaccepted.
// - rx_valid_i in COMMIT/RD_WAIT/RD_CAP/TX_*: byte dropped, err_o pulses, state unaffected.
// - Strobes mutually exclusive; at most one of reg_wr_lo_o, reg_wr_hi_o, ram_we_o high per cycle.
// - Address above 2^ADDR_W-1 wraps (truncation), no error.
// - Frame latency W: RAM write 1 cycle after DL byte; ack valid the following cycle.
// STRUCTURE
// - Shared package: opcode constants (OP_WRITE=8'h57, OP_READ=8'h52), reply constants (RSP_ACK=8'h4B,
//   RSP_ERR=8'h3F), state enum encoding.
// - One sub-module natural: ram_test_tx_holdreg (single-entry valid/ready byte holding register); rest flat FSM.
// TESTING
// - Reset: drive rst_ni=0 mid-'W' frame after AH -> all outputs 0, next 'R' frame decoded from IDLE correctly.
// - Write 57 01 23 BE EF -> hi strobe with reg_wdata_o=BEBE, lo strobe EFEF, ram_we_o 1 cycle at addr 0x123,
//   tx 0x4B.
// - Read 52 01 23 with RAM returning 0xBEEF -> tx 0xBE then 0xEF; hold tx_ready_i=0 5 cycles -> 0xBE stable.
// - Bad opcode 0x41 -> err_o 1-cycle pulse, tx 0x3F, busy_o returns 0 after accept.
// - Byte arriving during TX_H stall -> err_o pulse, read reply still 0xBE,0xEF, next frame decodes normally.
// - Address 57 FF FF 00 01 with ADDR_W=10 -> ram_addr_o=0x3FF, write issued, no error.

Source files
------------

// File: rtl/ram_test_cmd_decoder_pkg.sv
// Shared constants and state encoding for the block-RAM test command decoder.
package ram_test_cmd_decoder_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA_H,
    ST_DATA_L,
    ST_COMMIT,
    ST_TX_ACK,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_TX_H,
    ST_TX_L,
    ST_TX_ERR
  } state_t;

endpackage

// File: rtl/ram_test_cmd_decoder_tx_holdreg.sv
// Single-entry valid/ready byte holding register; a load takes priority over a
// same-cycle accept so back-to-back reply bytes need no bubble.
module ram_test_tx_holdreg (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_test_cmd_decoder.sv
// Byte-stream command decoder: parses 'W'/'R' frames, drives the byte-loadable
// data register and RAM port, and returns reply bytes over a valid/ready channel.
module ram_test_cmd_decoder
  import ram_test_cmd_decoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic [15:0]       reg_wdata_o,
  output logic              reg_wr_lo_o,
  output logic              reg_wr_hi_o,
  input  logic [15:0]       reg_q_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  input  logic [15:0]       ram_rdata_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              err_o
);

  state_t     state_q, state_d;
  logic       is_write_q;
  logic [7:0] addr_h_q;
  logic [7:0] rd_lo_q;
  logic       tx_load;
  logic [7:0] tx_byte;
  logic       tx_acc;

  // The RAM write port takes its data straight from the data register.
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q_i;

  assign tx_acc = tx_valid_o && tx_ready_i;
  assign busy_o = (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      is_write_q <= 1'b0;
      addr_h_q   <= '0;
      rd_lo_q    <= '0;
      ram_addr_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && rx_valid_i) is_write_q <= (rx_data_i == OP_WRITE);
      if (state_q == ST_ADDR_H && rx_valid_i) addr_h_q <= rx_data_i;
      if (state_q == ST_ADDR_L && rx_valid_i) ram_addr_o <= ADDR_W'({addr_h_q, rx_data_i});
      if (state_q == ST_RD_CAP) rd_lo_q <= ram_rdata_i[7:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    reg_wdata_o = '0;
    reg_wr_lo_o = 1'b0;
    reg_wr_hi_o = 1'b0;
    ram_we_o    = 1'b0;
    err_o       = 1'b0;
    tx_load     = 1'b0;
    tx_byte     = '0;
    unique case (state_q)
      ST_IDLE: if (rx_valid_i) begin
        if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
          state_d = ST_ADDR_H;
        end else begin
          err_o   = 1'b1;
          tx_load = 1'b1;
          tx_byte = RSP_ERR;
          state_d = ST_TX_ERR;
        end
      end
      ST_ADDR_H: if (rx_valid_i) state_d = ST_ADDR_L;
      ST_ADDR_L: if (rx_valid_i) state_d = is_write_q ? ST_DATA_H : ST_RD_WAIT;
      ST_DATA_H: if (rx_valid_i) begin
        reg_wr_hi_o = 1'b1;
        reg_wdata_o = {rx_data_i, rx_data_i};
        state_d     = ST_DATA_L;
      end
      ST_DATA_L: if (rx_valid_i) begin
        reg_wr_lo_o = 1'b1;
        reg_wdata_o = {rx_data_i, rx_data_i};
        state_d     = ST_COMMIT;
      end
      ST_COMMIT: begin
        err_o    = rx_valid_i;
        ram_we_o = 1'b1;
        tx_load  = 1'b1;
        tx_byte  = RSP_ACK;
        state_d  = ST_TX_ACK;
      end
      ST_RD_WAIT: begin
        err_o   = rx_valid_i;
        state_d = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        err_o   = rx_valid_i;
        tx_load = 1'b1;
        tx_byte = ram_rdata_i[15:8];
        state_d = ST_TX_H;
      end
      // Reload the low byte on the accept edge so it follows the high byte directly.
      ST_TX_H: begin
        err_o = rx_valid_i;
        if (tx_acc) begin
          tx_load = 1'b1;
          tx_byte = rd_lo_q;
          state_d = ST_TX_L;
        end
      end
      ST_TX_L, ST_TX_ACK, ST_TX_ERR: begin
        err_o = rx_valid_i;
        if (tx_acc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  ram_test_tx_holdreg u_tx_holdreg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (tx_load),
    .data_i  (tx_byte),
    .ready_i (tx_ready_i),
    .valid_o (tx_valid_o),
    .data_o  (tx_data_o)
  );

endmodule
